// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array core and its result drain.
package sa_pkg;

  localparam int SA_OUTWIDTH = 32;

  typedef enum logic [0:0] {
    DRAIN_IDLE = 1'b0,
    DRAIN_SEND = 1'b1
  } drain_state_t;

  // Index width for an n-entry array, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sa_result_drain.sv
// Captures a full row of column results from the systolic core into a shadow
// buffer, releases the core with outread, and streams the row out word by word.
module sa_result_drain
  import sa_pkg::*;
#(
  parameter int ROWS     = 8,
  parameter int OUTWIDTH = SA_OUTWIDTH,
  parameter int TIMEOUT  = 1024,
  parameter int CNTW     = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [OUTWIDTH-1:0]      routport [0:ROWS-1],
  input  logic [0:ROWS-1]          rvalidport,
  output logic                     outread,
  output logic [OUTWIDTH-1:0]      m_data,
  output logic [idx_w(ROWS)-1:0]   m_col,
  output logic                     m_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     busy,
  output logic                     err_partial,
  output logic [CNTW-1:0]          tiles_done,
  output drain_state_t             dbg_state
);

  // Stream handshake: a beat transfers on a rising clk edge where m_valid and
  // m_ready are both high; while m_valid is high and m_ready low, m_data,
  // m_col and m_last hold and m_valid is not withdrawn.

  localparam int COLW = idx_w(ROWS);
  localparam int WDW  = $clog2(TIMEOUT + 1);
  localparam logic [COLW-1:0] LAST_COL = COLW'(ROWS - 1);
  localparam logic [WDW-1:0]  WD_MAX   = WDW'(TIMEOUT);

  generate
    if (ROWS < 2) begin : g_rows_check
      $error("sa_result_drain: ROWS must be at least 2");
    end
  endgenerate

  drain_state_t        state;
  logic [OUTWIDTH-1:0] shadow [0:ROWS-1];
  logic [WDW-1:0]      wd_cnt;
  logic                all_valid;
  logic                partial;
  logic [COLW-1:0]     next_col;

  assign all_valid = &rvalidport;
  assign partial   = (|rvalidport) && !all_valid;
  assign next_col  = m_col + 1'b1;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= DRAIN_IDLE;
      outread     <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_col       <= '0;
      m_last      <= 1'b0;
      busy        <= 1'b0;
      err_partial <= 1'b0;
      tiles_done  <= '0;
      wd_cnt      <= '0;
      for (int i = 0; i < ROWS; i++) shadow[i] <= '0;
    end else begin
      outread <= 1'b0;
      case (state)
        DRAIN_IDLE: begin
          if (all_valid) begin
            // Column 0 is presented straight from the capture so it appears
            // in the first SEND cycle.
            shadow  <= routport;
            outread <= 1'b1;
            m_valid <= 1'b1;
            m_data  <= routport[0];
            m_col   <= '0;
            m_last  <= 1'b0;
            busy    <= 1'b1;
            wd_cnt  <= '0;
            state   <= DRAIN_SEND;
          end else if (partial) begin
            if (wd_cnt < WD_MAX) begin
              wd_cnt <= wd_cnt + 1'b1;
              if (wd_cnt == WD_MAX - 1'b1) err_partial <= 1'b1;
            end
          end else begin
            wd_cnt <= '0;
          end
        end
        DRAIN_SEND: begin
          wd_cnt <= '0;
          if (m_valid && m_ready) begin
            if (m_col == LAST_COL) begin
              m_valid    <= 1'b0;
              m_last     <= 1'b0;
              busy       <= 1'b0;
              tiles_done <= tiles_done + 1'b1;
              state      <= DRAIN_IDLE;
            end else begin
              m_col  <= next_col;
              m_data <= shadow[next_col];
              m_last <= (next_col == LAST_COL);
            end
          end
        end
        default: state <= DRAIN_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sa_result_drain.sv
// Directed bench for sa_result_drain: stimulus pushes expected beats into a
// queue, a negedge monitor pops and compares every transferred beat.
module tb_sa_result_drain;
  import sa_pkg::*;

  localparam int ROWS = 4;
  localparam int OW   = 32;
  localparam int TO   = 8;
  localparam int CW   = 4;
  localparam int EW   = 2 + 1 + OW;

  logic            clk = 1'b0;
  logic            rstn;
  logic [OW-1:0]   routport [0:ROWS-1];
  logic [0:ROWS-1] rvalidport;
  logic            outread;
  logic [OW-1:0]   m_data;
  logic [1:0]      m_col;
  logic            m_last;
  logic            m_valid;
  logic            m_ready;
  logic            busy;
  logic            err_partial;
  logic [CW-1:0]   tiles_done;
  drain_state_t    dbg_state;

  sa_result_drain #(.ROWS(ROWS), .OUTWIDTH(OW), .TIMEOUT(TO), .CNTW(CW)) dut (
    .clk(clk), .rstn(rstn), .routport(routport), .rvalidport(rvalidport),
    .outread(outread), .m_data(m_data), .m_col(m_col), .m_last(m_last),
    .m_valid(m_valid), .m_ready(m_ready), .busy(busy),
    .err_partial(err_partial), .tiles_done(tiles_done), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_outread = 0;
  logic [EW-1:0] exp_q[$];
  logic [CW-1:0] exp_tiles;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic          stall_v = 1'b0;
  logic [EW-1:0] stall_w;
  bit            have_prev = 0;
  int            prev_or = 0;

  always @(negedge clk) begin
    logic [EW-1:0] cur;
    cur = {m_col, m_last, m_data};
    if (!rstn) begin
      stall_v   = 1'b0;
      have_prev = 0;
    end else begin
      if (stall_v) check("stall_hold", {m_valid, cur}, {1'b1, stall_w});
      check("busy_vs_state", busy, (dbg_state == DRAIN_SEND));
      if (outread) begin
        n_outread++;
        if (have_prev) check("outread_spacing_ok", (cyc - prev_or) >= 5, 1);
        have_prev = 1;
        prev_or   = cyc;
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_beat: got %0h expected none", cur);
        end else begin
          check("beat", cur, exp_q.pop_front());
        end
      end
      stall_v = m_valid && !m_ready;
      stall_w = cur;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic present_row(input logic [OW-1:0] d0, d1, d2, d3);
    exp_q.push_back({2'd0, 1'b0, d0});
    exp_q.push_back({2'd1, 1'b0, d1});
    exp_q.push_back({2'd2, 1'b0, d2});
    exp_q.push_back({2'd3, 1'b1, d3});
    routport[0] = d0; routport[1] = d1; routport[2] = d2; routport[3] = d3;
    rvalidport  = 4'b1111;
  endtask

  // Core model: after outread is seen the core clears its valids.
  task automatic wait_outread();
    int n = 0;
    while (!outread && n < 60) begin tick(); n++; end
    if (!outread) begin
      total++; bad++;
      $display("FAIL outread_timeout: got 0 expected 1");
    end
    rvalidport = 4'b0000;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 100) begin tick(); n++; end
    check("drain_complete", {busy, 8'(exp_q.size())}, 9'd0);
  endtask

  task automatic drain_row(input logic [OW-1:0] d0, d1, d2, d3);
    present_row(d0, d1, d2, d3);
    wait_outread();
    wait_idle();
    exp_tiles = exp_tiles + 1'b1;
    check("tiles_done", tiles_done, exp_tiles);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n, or0;
    rstn = 1'b0; m_ready = 1'b0; rvalidport = '0;
    for (int i = 0; i < ROWS; i++) routport[i] = '0;
    exp_tiles = '0;
    tick(); tick();
    check("rst_outputs", {outread, m_valid, m_data, m_col, m_last, busy, err_partial, tiles_done},
          '0);
    rstn = 1'b1;
    tick();

    // Basic drain, busy high exactly ROWS cycles
    m_ready = 1'b1;
    present_row(32'h11, 32'h22, 32'h33, 32'h44);
    wait_outread();
    check("first_beat_col0", {m_valid, m_col, m_data}, {1'b1, 2'd0, 32'h11});
    n = 0;
    while (busy && n < 20) begin n++; tick(); end
    check("busy_cycles", n, 4);
    wait_idle();
    exp_tiles = exp_tiles + 1'b1;
    check("tiles_basic", tiles_done, exp_tiles);

    // Backpressure on column 1
    or0 = n_outread;
    present_row(32'h11, 32'h22, 32'h33, 32'h44);
    wait_outread();
    tick();
    m_ready = 1'b0;
    tick(); tick(); tick();
    check("bp_hold", {m_valid, m_col, m_data}, {1'b1, 2'd1, 32'h22});
    m_ready = 1'b1;
    wait_idle();
    exp_tiles = exp_tiles + 1'b1;
    check("tiles_bp", tiles_done, exp_tiles);
    check("bp_one_outread", n_outread - or0, 1);

    // Stale-valid immunity: new row raised during SEND
    present_row(32'h55, 32'h66, 32'h77, 32'h88);
    wait_outread();
    or0 = cyc;
    tick();
    present_row(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    tick();
    check("no_recapture_in_send", outread, 0);
    wait_outread();
    check("outread_gap", cyc - or0, 5);
    wait_idle();
    exp_tiles = exp_tiles + 2'd2;
    check("tiles_stale", tiles_done, exp_tiles);

    // Partial-valid watchdog
    rvalidport = 4'b1010;
    for (int i = 0; i < 6; i++) tick();
    check("err_before_timeout", err_partial, 0);
    for (int i = 0; i < 4; i++) tick();
    check("err_after_timeout", err_partial, 1);
    drain_row(32'hB0, 32'hB1, 32'hB2, 32'hB3);
    check("err_sticky", err_partial, 1);

    // Async reset in the middle of column 2
    present_row(32'hC0, 32'hC1, 32'hC2, 32'hC3);
    wait_outread();
    tick(); tick();
    check("at_col2", m_col, 2);
    #2 rstn = 1'b0;
    #1;
    check("async_rst", {m_valid, outread, busy, tiles_done, err_partial}, '0);
    exp_q.delete();
    exp_tiles = '0;
    tick(); tick();
    rstn = 1'b1;
    drain_row(32'hC0, 32'hC1, 32'hC2, 32'hC3);

    // Counter wrap after 16 drained rows
    for (int r = 1; r < 16; r++)
      drain_row(32'(r), 32'(r + 16), 32'(r + 32), 32'(r + 48));
    check("tiles_wrapped", tiles_done, 0);
    check("wrap_no_side_effect", {err_partial, busy, m_valid}, 0);

    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
